seq_alu: RTL and testbench

Parametrised, clocked successor to the combinational 12-op ALU. It takes operands through a valid/ready handshake and computes the full-width product and the quotient/remainder iteratively over WIDTH cycles. It returns a registered result, a high half and status flags through a held output handshake. It sits between the operand register file and the bus result latch of the CPU datapath.

---
 rtl/seq_alu.sv | 195 +++++++++++++++++++
 tb/tb_seq_alu.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/sub, WIDTH-cycle shift-add MUL and restoring DIV; one op in flight.
// Latency 1 cycle (WIDTH+1 for MUL/DIV); result held with out_valid until out_ready, in_ready low meanwhile.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz,
    output logic             flag_err
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int M  = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic z, n, c, v, dz, err;
    } flags_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    flags_t           flags_q, flags_d;
    logic [1:0]       rst_sync_q;

    // Release is synchronised so the first accept never races the reset edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    logic [WIDTH:0]   add_s, sub_s;
    logic [WIDTH-1:0] imm_res, imm_hi;
    flags_t           imm_fl;

    always_comb begin
        add_s   = {1'b0, opa} + {1'b0, opb};
        sub_s   = {1'b0, opa} - {1'b0, opb};
        imm_res = '0;
        imm_hi  = '0;
        imm_fl  = '0;
        case (op)
            4'h0: begin
                imm_res  = add_s[M:0];
                imm_fl.c = add_s[WIDTH];
                imm_fl.v = (opa[M] == opb[M]) && (add_s[M] != opa[M]);
            end
            4'h1: begin
                imm_res  = sub_s[M:0];
                imm_fl.c = sub_s[WIDTH];
                imm_fl.v = (opa[M] != opb[M]) && (sub_s[M] != opa[M]);
            end
            4'h2: imm_res = '0;
            4'h3: begin
                imm_res   = '1;
                imm_hi    = opa;
                imm_fl.dz = 1'b1;
            end
            4'h4: imm_res = ~opa;
            4'h5: imm_res = opa & opb;
            4'h6: imm_res = opa | opb;
            4'h7: imm_res = ~(opa & opb);
            4'h8: imm_res = ~(opa | opb);
            4'h9: imm_res = opa ^ opb;
            4'hA: begin imm_res = {opa[M-1:0], 1'b0};   imm_fl.c = opa[M]; end
            4'hB: begin imm_res = {1'b0, opa[M:1]};     imm_fl.c = opa[0]; end
            4'hC: begin imm_res = {opa[M], opa[M:1]};   imm_fl.c = opa[0]; end
            4'hD: begin imm_res = {opa[M-1:0], opa[M]}; imm_fl.c = opa[M]; end
            default: imm_fl.err = 1'b1;
        endcase
        // Divide-by-zero and illegal ops report only their dedicated flag.
        if (!imm_fl.err && !imm_fl.dz) begin
            imm_fl.z = (imm_res == '0);
            imm_fl.n = imm_res[M];
        end
    end

    // One iteration step of each multi-cycle datapath on the shared hi/lo pair.
    logic [WIDTH:0]   mul_s, div_sh, div_sub;
    logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
    logic             div_bit;

    always_comb begin
        mul_s   = {1'b0, hi_q} + {1'b0, a_q & {WIDTH{lo_q[0]}}};
        mul_hi  = mul_s[WIDTH:1];
        mul_lo  = {mul_s[0], lo_q[M:1]};
        div_sh  = {hi_q, lo_q[M]};
        div_sub = div_sh - {1'b0, b_q};
        div_bit = (div_sh >= {1'b0, b_q});
        div_hi  = div_bit ? div_sub[M:0] : div_sh[M:0];
        div_lo  = {lo_q[M-1:0], div_bit};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                a_d   = opa;
                b_d   = opb;
                op_d  = op;
                cnt_d = '0;
                hi_d  = '0;
                if (op == 4'h2) begin
                    lo_d    = opb;
                    state_d = BUSY;
                end else if (op == 4'h3 && opb != '0) begin
                    lo_d    = opa;
                    state_d = BUSY;
                end else begin
                    res_d    = imm_res;
                    res_hi_d = imm_hi;
                    flags_d  = imm_fl;
                    state_d  = DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                hi_d  = (op_q == 4'h2) ? mul_hi : div_hi;
                lo_d  = (op_q == 4'h2) ? mul_lo : div_lo;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d    = lo_d;
                    res_hi_d = hi_d;
                    flags_d  = '0;
                    flags_d.z = (lo_d == '0);
                    flags_d.n = lo_d[M];
                    flags_d.v = (op_q == 4'h2) && (hi_d != '0);
                    state_d  = DONE;
                end
            end
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && rst_sync_q[1];
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign result_hi = res_hi_q;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;
    assign flag_dz   = flags_q.dz;
    assign flag_err  = flags_q.err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8; flags compared as {z,n,c,v,dz,err}.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] opa = '0, opb = '0;
    logic [3:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result, result_hi;
    logic       flag_z, flag_n, flag_c, flag_v, flag_dz, flag_err;
    logic [5:0] fl;
    int         checks = 0;
    int         failures = 0;

    seq_alu #(.WIDTH(8), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opa(opa), .opb(opb), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .flag_dz(flag_dz), .flag_err(flag_err)
    );

    always #5 clk = ~clk;
    assign fl = {flag_z, flag_n, flag_c, flag_v, flag_dz, flag_err};

    // Called #1 after a rising edge; returns cycles from accept to out_valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                         output int lat, output logic busy_rdy);
        int g;
        opa = a; opb = b; op = o; in_valid = 1'b1; g = 0;
        while (!in_ready && g < 20) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        in_valid = 1'b0; lat = 1; busy_rdy = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) busy_rdy = 1'b1;
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || result_hi !== 8'h00 || fl !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b res=%h hi=%h fl=%b, want 0/00/00/000000",
                     out_valid, result, result_hi, fl);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_addsub();
        int lat; logic br;
        do_op(8'h6A, 8'h3B, 4'h0, lat, br);
        checks++;
        if (lat != 1 || result !== 8'hA5 || fl !== 6'b010100) begin
            failures++;
            $display("FAIL add: got lat=%0d res=%h fl=%b, want 1/A5/010100", lat, result, fl);
        end
        take();
        do_op(8'h6A, 8'h3B, 4'h1, lat, br);
        checks++;
        if (lat != 1 || result !== 8'h2F || fl !== 6'b000000) begin
            failures++;
            $display("FAIL sub: got lat=%0d res=%h fl=%b, want 1/2F/000000", lat, result, fl);
        end
        take();
    endtask

    task automatic test_muldiv();
        int lat; logic br;
        do_op(8'h6A, 8'h3B, 4'h2, lat, br);
        checks++;
        if (lat != 9 || br !== 1'b0) begin
            failures++;
            $display("FAIL mul_timing: got lat=%0d ready_while_busy=%b, want 9/0", lat, br);
        end
        checks++;
        if (result !== 8'h6E || result_hi !== 8'h18 || fl !== 6'b000100) begin
            failures++;
            $display("FAIL mul: got res=%h hi=%h fl=%b, want 6E/18/000100", result, result_hi, fl);
        end
        take();
        do_op(8'h6A, 8'h3B, 4'h3, lat, br);
        checks++;
        if (lat != 9 || result !== 8'h01 || result_hi !== 8'h2F || fl !== 6'b000000) begin
            failures++;
            $display("FAIL div: got lat=%0d res=%h hi=%h fl=%b, want 9/01/2F/000000",
                     lat, result, result_hi, fl);
        end
        take();
        do_op(8'h6A, 8'h00, 4'h3, lat, br);
        checks++;
        if (lat != 1 || result !== 8'hFF || result_hi !== 8'h6A || fl !== 6'b000010) begin
            failures++;
            $display("FAIL div_zero: got lat=%0d res=%h hi=%h fl=%b, want 1/FF/6A/000010",
                     lat, result, result_hi, fl);
        end
        take();
    endtask

    task automatic test_logic();
        logic [3:0] t_op  [12] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        logic [7:0] t_a   [12] = '{8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h6A, 8'h95, 8'h95, 8'h6A, 8'h6A};
        logic [7:0] t_res [12] = '{8'h95, 8'h2A, 8'h7B, 8'hD5, 8'h84, 8'h51, 8'hD4, 8'h35, 8'hCA, 8'h2B, 8'h00, 8'h00};
        logic [5:0] t_fl  [12] = '{6'b010000, 6'b000000, 6'b000000, 6'b010000, 6'b010000, 6'b000000,
                                   6'b010000, 6'b000000, 6'b011000, 6'b001000, 6'b000001, 6'b000001};
        int lat; logic br;
        for (int i = 0; i < 12; i++) begin
            do_op(t_a[i], 8'h3B, t_op[i], lat, br);
            checks++;
            if (lat != 1 || result !== t_res[i] || result_hi !== 8'h00 || fl !== t_fl[i]) begin
                failures++;
                $display("FAIL op_%h: got lat=%0d res=%h hi=%h fl=%b, want 1/%h/00/%b",
                         t_op[i], lat, result, result_hi, fl, t_res[i], t_fl[i]);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic br; logic held_ok;
        do_op(8'h6A, 8'h3B, 4'h0, lat, br);
        held_ok = 1'b1;
        opa = 8'h01; opb = 8'h02; op = 4'h1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'hA5 || fl !== 6'b010100)
                held_ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (held_ok !== 1'b1) begin
            failures++;
            $display("FAIL hold: got vld=%b rdy=%b res=%h fl=%b, want 1/0/A5/010100 for 5 cycles",
                     out_valid, in_ready, result, fl);
        end
        take();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake: got vld=%b rdy=%b, want 0/1", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ignored_input: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic br; logic stale;
        opa = 8'h6A; opb = 8'h3B; op = 4'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || result_hi !== 8'h00 || fl !== 6'b0) begin
            failures++;
            $display("FAIL reset_mid: got vld=%b res=%h hi=%h fl=%b, want 0/00/00/000000",
                     out_valid, result, result_hi, fl);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: got stale_valid=%b rdy=%b, want 0/1", stale, in_ready);
        end
        do_op(8'hFF, 8'h01, 4'h0, lat, br);
        checks++;
        if (lat != 1 || result !== 8'h00 || fl !== 6'b101000) begin
            failures++;
            $display("FAIL add_wrap: got lat=%0d res=%h fl=%b, want 1/00/101000", lat, result, fl);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_muldiv();
        test_logic();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
